// File: rtl/data_memory_pkg.sv
// Shared sizing constants for the MEM-stage data memory.
package data_memory_pkg;
    localparam int DATAMEM_ADDR_WIDTH = 5;
    localparam int DATAMEM_DATA_WIDTH = 64;
    localparam int DATAMEM_DEPTH      = 32;
endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read, synchronous clear.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DATAMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DATAMEM_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] D_in,
    output logic [DATA_WIDTH-1:0] D_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Reset has priority over a coincident write; no write-first bypass on the read port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (WE) begin
            mem_q[ADDR] <= D_in;
        end
    end

    assign D_out = mem_q[ADDR];

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; inputs change on the falling edge.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic        we;
    logic [63:0] dIn;
    logic [63:0] dOut;

    int checkCount = 0;
    int failCount  = 0;

    data_memory dut (
        .CLK   (clk),
        .RST   (rst),
        .ADDR  (addr),
        .WE    (we),
        .D_in  (dIn),
        .D_out (dOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, observed, expected);
        end
    endtask

    // Drive one write across the next rising edge; returns on the following falling edge.
    task automatic applyStimulus(input logic [4:0] a, input logic [63:0] d);
        addr = a;
        dIn  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    function automatic logic [63:0] patternFor(input int i);
        logic [63:0] v;
        v = {32'hA5A5_0000 | 32'(i), 32'h0000_1000 + 32'(i * 3)};
        return v;
    endfunction

    initial begin
        rst  = 1'b1;
        we   = 1'b0;
        addr = '0;
        dIn  = '0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            addr = 5'(i);
            #1;
            checkOutput($sformatf("resetSweep[%0d]", i), dOut, 64'd0);
        end

        @(negedge clk);
        applyStimulus(5'd11, 64'd150);
        addr = 5'd11;
        dIn  = 64'd300;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("holdAddr11[%0d]", i), dOut, 64'd150);
        end

        applyStimulus(5'd11, 64'd151);
        applyStimulus(5'd11, 64'd152);
        addr = 5'd11;
        #1;
        checkOutput("lastWriteWins", dOut, 64'd152);

        applyStimulus(5'd0, 64'hDEAD_BEEF_0000_0001);
        applyStimulus(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        addr = 5'd0;  #1; checkOutput("boundAddr0", dOut, 64'hDEAD_BEEF_0000_0001);
        addr = 5'd31; #1; checkOutput("boundAddr31", dOut, 64'hFFFF_FFFF_FFFF_FFFF);
        addr = 5'd1;  #1; checkOutput("boundAddr1", dOut, 64'd0);
        addr = 5'd30; #1; checkOutput("boundAddr30", dOut, 64'd0);

        @(negedge clk);
        applyStimulus(5'd5, 64'd7);
        addr = 5'd5;
        dIn  = 64'd9;
        we   = 1'b1;
        #1;
        checkOutput("rdwBeforeEdge", dOut, 64'd7);
        @(negedge clk);
        we = 1'b0;
        #1;
        checkOutput("rdwAfterEdge", dOut, 64'd9);

        @(negedge clk);
        applyStimulus(5'd3, 64'd42);
        addr = 5'd3;
        #1;
        checkOutput("preResetAddr3", dOut, 64'd42);
        @(negedge clk);
        rst = 1'b1;
        we  = 1'b1;
        dIn = 64'd55;
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
        #1;
        checkOutput("resetWinsAddr3", dOut, 64'd0);
        for (int i = 0; i < 32; i++) begin
            addr = 5'(i);
            #1;
            checkOutput($sformatf("resetPrioSweep[%0d]", i), dOut, 64'd0);
        end

        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(5'(i), patternFor(i));
        end
        addr = 5'd7;  #1; checkOutput("asyncRead7", dOut, patternFor(7));
        addr = 5'd20; #1; checkOutput("asyncRead20", dOut, patternFor(20));
        addr = 5'd31; #1; checkOutput("asyncRead31", dOut, patternFor(31));
        addr = 5'd0;  #1; checkOutput("asyncRead0", dOut, patternFor(0));

        @(negedge clk);
        we  = 1'b0;
        dIn = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 32; i++) begin
            addr = 5'(i);
            @(negedge clk);
            checkOutput($sformatf("noWriteSweep[%0d]", i), dOut, patternFor(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-addressed data memory for the RISC-V datapath: 32 words x 64 bits.
- Single write port, synchronous write on the rising clock edge.
- Single asynchronous (combinational) read port.
- Sits in the MEM stage; the ALU result drives ADDR and the register-file rs2 value drives D_in for stores.

Parameters:
- ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 64, word width in bits.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- ADDR  input  ADDR_WIDTH  word address for both read and write.
- WE  input  1  write enable.
- D_in  input  DATA_WIDTH  write data.
- D_out  output  DATA_WIDTH  read data = mem[ADDR].

Behaviour:
- One clock domain, CLK. Reset is synchronous and active-high on RST.
- Storage: array of 2**ADDR_WIDTH words of DATA_WIDTH bits.
- Reset: at a rising CLK edge with RST=1, every word is cleared to 0.
  - D_out therefore reads 0 from the edge after reset onward.
  - Before the first reset, contents are undefined.
- Write: at a rising CLK edge with RST=0 and WE=1, mem[ADDR] <= D_in. Latency is 1 edge.
- WE=0: no storage change; D_in is ignored.
- Read: D_out = mem[ADDR] combinationally, with zero-cycle latency. It follows ADDR changes within the same cycle and is independent of WE.
- Read-during-write, same address:
  - Before the edge, D_out shows the old contents.
  - After the edge, D_out shows the newly written data.
  - No write-first bypass.
- Simultaneous RST=1 and WE=1: reset wins; all words are 0 and the write is discarded.
- Reset mid-operation: the next rising edge with RST=1 clears all contents regardless of prior writes.
- Address range: all 5-bit values 0..31 are valid. There is no wrap or out-of-range case because the address width exactly covers the depth.
- Repeated writes to one address: last write wins.
- No X-propagation masking. Behaviour for X/Z inputs is not specified.

Decomposition:
- Shared package holds:
  - DATAMEM_ADDR_WIDTH = 5
  - DATAMEM_DATA_WIDTH = 64
  - DATAMEM_DEPTH = 32
- No sub-module: a single flat module with the array, reset loop, write logic and continuous read assign.

Test Plan:
- Reset: RST=1 for one edge, then sweep ADDR 0..31 with WE=0 -> D_out = 0 at every address.
- Write then hold: WE=1, ADDR=11, D_in=150 for one edge. Then WE=0, D_in=300, ADDR=11 for 10 cycles -> D_out = 150 throughout; the 300 is never stored.
- Boundary addresses: write 0xDEADBEEF_00000001 at 0 and 0xFFFFFFFF_FFFFFFFF at 31 -> reading 0 and 31 returns those values; 1 and 30 still read 0.
- Read-during-write: ADDR=5 holds 7; set WE=1, D_in=9 -> D_out = 7 before the edge, 9 after it.
- Reset priority: ADDR=3 holds 42; assert RST=1 and WE=1 with D_in=55 on the same edge -> ADDR 3 reads 0 afterwards, and every other address reads 0.
- Async read: with distinct values in 0..31, change ADDR mid-cycle with no clock edge -> D_out updates immediately to mem[new ADDR].
